// File: rtl/msdf_run_sequencer.sv
// msdf_run_sequencer
//   Avalon-MM run sequencer for the MSDF operator test harness. The host
//   programs START, NUM, LAT and REPEAT, then writes GO. The block streams
//   operand-RAM read addresses and replays each one, LAT cycles later, as a
//   result-RAM write. This repeats for REPEAT passes. The CYCLES register
//   holds the busy-cycle total of the last run.
//
// Ports
//   avalon_clock          single clock
//   resetn                asynchronous active-low reset
//   address/write/writedata/read/readdata   Avalon-MM slave (readdata registered)
//   r_addr_a, r_addr_b    operand RAM read address (both identical)
//   w_addr, we            result RAM write address / enable
//   we_read_a, we_read_b  operand RAM write enables, tied low
//
// Register map
//   0 CTRL (W: b0 GO, b1 ABORT) / STATUS (R: b0 busy, b1 done, b2 aborted, b3 error)
//   1 START   2 NUM   3 ID (RO)   4 LAT   5 REPEAT (0 means 1)   6 CYCLES (RO)
module msdf_run_sequencer #(
  parameter int ID         = 1,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_LAT    = 16
) (
  input  logic                  avalon_clock,
  input  logic                  resetn,
  input  logic [2:0]            address,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic                  read,
  output logic [31:0]           readdata,
  output logic [ADDR_WIDTH-1:0] r_addr_a,
  output logic [ADDR_WIDTH-1:0] r_addr_b,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  we,
  output logic                  we_read_a,
  output logic                  we_read_b
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [ADDR_WIDTH:0]   r_num;
  logic [31:0]           r_lat;
  logic [15:0]           r_repeat;
  logic [31:0]           r_cycles;
  logic                  r_done;
  logic                  r_aborted;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_k;
  logic [LAT_W-1:0]      r_d;
  logic [15:0]           r_pass;
  logic [31:0]           r_rdata;
  logic                  r_dl_vld  [MAX_LAT];
  logic [ADDR_WIDTH-1:0] r_dl_addr [MAX_LAT];

  logic                  w_busy;
  logic                  w_go;
  logic                  w_abort;
  logic                  w_lat_ok;
  logic [LAT_W-1:0]      w_lat_m1;
  logic                  w_last_issue;
  logic                  w_last_drain;
  logic                  w_push;
  logic [31:0]           w_rd;

  assign w_busy       = (r_state != S_IDLE);
  // ABORT in the same write suppresses GO
  assign w_go         = write && (address == 3'd0) && writedata[0] && !writedata[1];
  assign w_abort      = write && (address == 3'd0) && writedata[1];
  assign w_lat_ok     = (r_lat != 32'd0) && (r_lat <= 32'(MAX_LAT));
  assign w_lat_m1     = r_lat[LAT_W-1:0] - LAT_W'(1);
  assign w_last_issue = (r_k == r_num - 1'b1);
  assign w_last_drain = (r_d == w_lat_m1);
  assign w_push       = (r_state == S_ISSUE);

  assign readdata  = r_rdata;
  assign r_addr_a  = r_addr;
  assign r_addr_b  = r_addr;
  assign we        = r_dl_vld[0];
  assign w_addr    = r_dl_addr[0];
  assign we_read_a = 1'b0;
  assign we_read_b = 1'b0;

  always_comb begin
    w_rd = 32'd0;
    case (address)
      3'd0:    w_rd = {28'd0, r_error, r_aborted, r_done, w_busy};
      3'd1:    w_rd = 32'(r_start);
      3'd2:    w_rd = 32'(r_num);
      3'd3:    w_rd = 32'(ID);
      3'd4:    w_rd = r_lat;
      3'd5:    w_rd = {16'd0, r_repeat};
      3'd6:    w_rd = r_cycles;
      default: w_rd = 32'd0;
    endcase
  end

  // Delay line: entries are inserted at slot LAT-1 and shift toward slot 0,
  // which drives we/w_addr directly. Slots above LAT-1 stay empty because LAT
  // can only change in IDLE, when the line has fully drained or been cleared.
  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        r_dl_vld[i]  <= 1'b0;
        r_dl_addr[i] <= '0;
      end
    end else if (w_busy && w_abort) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        r_dl_vld[i]  <= 1'b0;
        r_dl_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_LAT - 1; i++) begin
        if (w_lat_m1 == LAT_W'(i)) begin
          r_dl_vld[i]  <= w_push;
          r_dl_addr[i] <= r_addr;
        end else begin
          r_dl_vld[i]  <= r_dl_vld[i+1];
          r_dl_addr[i] <= r_dl_addr[i+1];
        end
      end
      if (w_lat_m1 == LAT_W'(MAX_LAT - 1)) begin
        r_dl_vld[MAX_LAT-1]  <= w_push;
        r_dl_addr[MAX_LAT-1] <= r_addr;
      end else begin
        r_dl_vld[MAX_LAT-1]  <= 1'b0;
        r_dl_addr[MAX_LAT-1] <= '0;
      end
    end
  end

  // Register file, run FSM and status
  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_start   <= '0;
      r_num     <= '0;
      r_lat     <= '0;
      r_repeat  <= '0;
      r_cycles  <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_error   <= 1'b0;
      r_addr    <= '0;
      r_k       <= '0;
      r_d       <= '0;
      r_pass    <= '0;
      r_rdata   <= '0;
    end else begin
      if (read) r_rdata <= w_rd;

      case (r_state)
        S_IDLE: begin
          if (write) begin
            case (address)
              3'd1:    r_start  <= writedata[ADDR_WIDTH-1:0];
              3'd2:    r_num    <= writedata[ADDR_WIDTH:0];
              3'd4:    r_lat    <= writedata;
              3'd5:    r_repeat <= writedata[15:0];
              default: ;
            endcase
          end
          if (w_go) begin
            if (!w_lat_ok) begin
              r_error <= 1'b1;
            end else if (r_num == '0) begin
              r_done    <= 1'b1;
              r_aborted <= 1'b0;
              r_error   <= 1'b0;
              r_cycles  <= '0;
            end else begin
              r_done    <= 1'b0;
              r_aborted <= 1'b0;
              r_error   <= 1'b0;
              r_cycles  <= '0;
              r_addr    <= r_start;
              r_k       <= '0;
              r_d       <= '0;
              r_pass    <= (r_repeat == 16'd0) ? 16'd1 : r_repeat;
              r_state   <= S_ISSUE;
            end
          end
        end

        S_ISSUE, S_DRAIN: begin
          // the cycle on which ABORT lands still counts as a busy cycle
          r_cycles <= r_cycles + 32'd1;
          if (w_abort) begin
            r_state   <= S_IDLE;
            r_aborted <= 1'b1;
          end else if (r_state == S_ISSUE) begin
            if (w_last_issue) begin
              r_d     <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
              r_k    <= r_k + 1'b1;
            end
          end else begin
            if (w_last_drain) begin
              if (r_pass == 16'd1) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_pass  <= r_pass - 16'd1;
                r_addr  <= r_start;
                r_k     <= '0;
                r_state <= S_ISSUE;
              end
            end else begin
              r_d <= r_d + LAT_W'(1);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msdf_run_sequencer.sv
module tb_msdf_run_sequencer;

  logic        clk;
  logic        resetn;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic [10:0] r_addr_a;
  logic [10:0] r_addr_b;
  logic [10:0] w_addr;
  logic        we;
  logic        we_read_a;
  logic        we_read_b;

  int n_total;
  int n_bad;

  msdf_run_sequencer #(.ID(1), .ADDR_WIDTH(11), .MAX_LAT(16)) dut (
    .avalon_clock(clk),
    .resetn      (resetn),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .read        (read),
    .readdata    (readdata),
    .r_addr_a    (r_addr_a),
    .r_addr_b    (r_addr_b),
    .w_addr      (w_addr),
    .we          (we),
    .we_read_a   (we_read_a),
    .we_read_b   (we_read_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
    d       = readdata;
  endtask

  // Program and launch a run, then check every cycle against the expected
  // timeline: pass cycle j (1-based) issues START+j-1 for j<=NUM and writes
  // START+(j-LAT-1) for j>LAT. STATUS is read every cycle; readdata seen in
  // cycle c reflects the status of cycle c-1.
  task automatic go_run(input int start, input int num, input int lat, input int rep);
    int          eff;
    int          total;
    int          j;
    logic        exp_we;
    logic [31:0] d;
    eff   = (rep == 0) ? 1 : rep;
    total = eff * (num + lat);
    wr(3'd1, 32'(start));
    wr(3'd2, 32'(num));
    wr(3'd4, 32'(lat));
    wr(3'd5, 32'(rep));
    wr(3'd0, 32'd1);
    address = 3'd0;
    read    = 1'b1;
    for (int c = 1; c <= total + 3; c++) begin
      j = (c <= total) ? ((c - 1) % (num + lat)) + 1 : 0;
      if (j >= 1 && j <= num) begin
        chk("raddr_a", 32'(r_addr_a), (start + j - 1) & 32'h7FF);
        chk("raddr_b", 32'(r_addr_b), (start + j - 1) & 32'h7FF);
      end
      exp_we = (j > lat);
      chk("we", 32'(we), 32'(exp_we));
      if (exp_we) chk("waddr", 32'(w_addr), (start + j - lat - 1) & 32'h7FF);
      if (c >= 2) chk("status", 32'(readdata[1:0]), (c - 1 <= total) ? 32'd1 : 32'd2);
      @(negedge clk);
    end
    read = 1'b0;
    rd(3'd6, d);
    chk("cycles", d, 32'(total));
  endtask

  initial begin
    logic [31:0] d;
    int          nw;
    logic [10:0] last;
    n_total   = 0;
    n_bad     = 0;
    resetn    = 1'b0;
    address   = 3'd0;
    write     = 1'b0;
    writedata = 32'd0;
    read      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", 32'(w_addr), 32'd0);
    chk("rst_raddr", 32'(r_addr_a), 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    chk("tie_we_rd", 32'({we_read_a, we_read_b}), 32'd0);
    resetn = 1'b1;
    rd(3'd0, d); chk("rst_status", d, 32'd0);
    rd(3'd3, d); chk("id", d, 32'd1);
    rd(3'd7, d); chk("unmapped", d, 32'd0);

    // 1: basic single pass
    go_run(0, 4, 3, 1);
    rd(3'd0, d); chk("t1_status", d, 32'h2);

    // 2: address wrap, REPEAT=0 behaves as one pass
    go_run(2046, 4, 2, 0);

    // 3: three back-to-back passes
    go_run(0, 3, 1, 3);
    rd(3'd0, d); chk("t3_status", d, 32'h2);

    // deepest latency
    go_run(5, 2, 16, 1);

    // 4: abort mid-run
    wr(3'd1, 32'd0); wr(3'd2, 32'd100); wr(3'd4, 32'd4); wr(3'd5, 32'd1);
    wr(3'd0, 32'd1);
    repeat (9) @(negedge clk);
    chk("t4_we_pre", 32'(we), 32'd1);
    chk("t4_waddr_pre", 32'(w_addr), 32'd5);
    address = 3'd0; writedata = 32'd2; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    nw = 0;
    for (int c = 0; c < 4; c++) begin
      if (we) nw++;
      @(negedge clk);
    end
    chk("t4_we_after", 32'(nw), 32'd0);
    rd(3'd0, d); chk("t4_status", d, 32'h4);
    rd(3'd6, d); chk("t4_cycles", d, 32'd10);
    go_run(0, 2, 4, 1);
    rd(3'd0, d); chk("t4_rego_status", d, 32'h2);

    // 5: bad latency and empty run
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd1);
    nw = 0;
    for (int c = 0; c < 5; c++) begin
      if (we) nw++;
      @(negedge clk);
    end
    chk("t5_lat0_we", 32'(nw), 32'd0);
    rd(3'd0, d); chk("t5_lat0_err", 32'(d[3]), 32'd1);
    chk("t5_lat0_busy", 32'(d[0]), 32'd0);
    wr(3'd4, 32'd17);
    wr(3'd0, 32'd1);
    rd(3'd0, d); chk("t5_lat17_err", 32'(d[3]), 32'd1);
    chk("t5_lat17_busy", 32'(d[0]), 32'd0);
    wr(3'd2, 32'd0); wr(3'd4, 32'd2);
    wr(3'd0, 32'd1);
    nw = 0;
    for (int c = 0; c < 6; c++) begin
      if (we) nw++;
      @(negedge clk);
    end
    chk("t5_num0_we", 32'(nw), 32'd0);
    rd(3'd0, d); chk("t5_num0_done", 32'(d[1]), 32'd1);
    chk("t5_num0_busy", 32'(d[0]), 32'd0);
    rd(3'd6, d); chk("t5_num0_cycles", d, 32'd0);

    // 6a: NUM write while busy is ignored
    wr(3'd1, 32'd0); wr(3'd2, 32'd5); wr(3'd4, 32'd2); wr(3'd5, 32'd1);
    wr(3'd0, 32'd1);
    wr(3'd2, 32'd50);
    nw = 0; last = '0;
    for (int c = 0; c < 20; c++) begin
      if (we) begin
        nw++;
        last = w_addr;
      end
      @(negedge clk);
    end
    chk("t6_nwrites", 32'(nw), 32'd5);
    chk("t6_last", 32'(last), 32'd4);
    rd(3'd2, d); chk("t6_num", d, 32'd5);
    rd(3'd6, d); chk("t6_cycles", d, 32'd7);

    // 6b: reset mid-run
    wr(3'd1, 32'd7); wr(3'd2, 32'd20); wr(3'd4, 32'd3); wr(3'd5, 32'd2);
    wr(3'd0, 32'd1);
    repeat (6) @(negedge clk);
    chk("t6_we_before_rst", 32'(we), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_we", 32'(we), 32'd0);
    chk("t6_rst_raddr", 32'(r_addr_a), 32'd0);
    chk("t6_rst_waddr", 32'(w_addr), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    nw = 0;
    for (int c = 0; c < 6; c++) begin
      if (we) nw++;
      @(negedge clk);
    end
    chk("t6_rst_nwrites", 32'(nw), 32'd0);
    rd(3'd1, d); chk("t6_rst_start", d, 32'd0);
    rd(3'd2, d); chk("t6_rst_num", d, 32'd0);
    rd(3'd4, d); chk("t6_rst_lat", d, 32'd0);
    rd(3'd5, d); chk("t6_rst_repeat", d, 32'd0);
    rd(3'd6, d); chk("t6_rst_cycles", d, 32'd0);
    rd(3'd0, d); chk("t6_rst_status", d, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
